mem_stage_sram: RTL and testbench

Memory stage of the ARM pipeline: it sits between the EXE stage register and the MEM stage register. It performs data-memory loads and stores against an internal word array with a fixed, multi-cycle access time. While an access is in flight it drops `ready` so the pipeline freezes. The loaded word appears on `data_mem_out`, which the MEM stage register captures on the cycle `ready` returns high.

---
 rtl/mem_stage_sram.sv | 130 +++++++++++++
 tb/tb_mem_stage_sram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: memory stage of the ARM pipeline.
// Performs loads and stores against an internal word array with a fixed
// multi-cycle access time, and drops ready while an access is in flight.
// The pipeline holds every upstream input steady while ready is low.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned accesses.
// A flagged access suppresses its store, returns zero and raises
// align_fault for its DONE cycle.
module mem_stage_sram #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] address_in,
  input  logic [31:0] store_data_in,
  output logic [31:0] data_mem_out,
  output logic        ready,
  output logic        align_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        rdata;
  logic               req;
  logic               access;
  logic               misaligned;
  logic               do_write;
  logic [31:0]        addr_off;
  logic [IDX_W-1:0]   word_idx;

  // The array is not touched by rst and starts out all zeros.
  logic [31:0] mem_array [DEPTH_WORDS] = '{default: 32'd0};

  assign req      = mem_read_in | mem_write_in;
  assign addr_off = address_in - BASE_ADDR;
  // Out-of-range addresses wrap modulo the depth by simple truncation.
  assign word_idx = addr_off[IDX_W+1:2];

  // The access happens on the edge that ends the last WAIT cycle.
  assign access   = (state == S_WAIT) && (cnt == '0);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = |address_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign do_write = access && mem_write_in && !misaligned;

  // Bits of the offset that do not select a word are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_off[31:IDX_W+2], addr_off[1:0]};

  // Pipeline may advance when idle with no request, or when the access has just completed.
  assign ready = ((state == S_IDLE) && !req) || (state == S_DONE);

  assign data_mem_out = rdata;

  // Access FSM: IDLE -> WAIT (WAIT_CYCLES cycles) -> DONE -> IDLE, with the load result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            cnt   <= CNT_W'(WAIT_CYCLES - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= S_DONE;
            if (misaligned)
              rdata <= '0;
            else if (mem_write_in)
              rdata <= store_data_in;   // write wins when both requests are set
            else
              rdata <= mem_array[word_idx];
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Array write port; an asynchronous reset forces IDLE, so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (do_write)
      mem_array[word_idx] <= store_data_in;
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_q;

  // Fault flag is set by a misaligned access edge and so is high only in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_q <= 1'b0;
    else
      fault_q <= access && misaligned;
  end

  assign align_fault = fault_q;
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Testbench for mem_stage_sram: directed scenarios followed by random
// loads, stores and non-memory instructions. Outputs are compared every
// cycle against a transaction-level model of the memory.
module tb_mem_stage_sram;

  localparam int W     = 3;
  localparam int DEPTH = 64;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] address_in;
  logic [31:0] store_data_in;
  logic [31:0] data_mem_out;
  logic        ready;
  logic        align_fault;

  mem_stage_sram #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in),
    .address_in(address_in),
    .store_data_in(store_data_in),
    .data_mem_out(data_mem_out),
    .ready(ready),
    .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expectations for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        exp_ready;
  logic [31:0] exp_data;
  logic        exp_fault;
  logic [15:0] rdy_log = '0;

  // Model state: memory contents and last load result.
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] cur_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("data_mem_out", data_mem_out, exp_data);
      chk("align_fault", 32'(align_fault), 32'(exp_fault));
    end
    rdy_log = {rdy_log[14:0], ready};
  end

  // Issue one instruction and hold it for as long as the memory takes.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic        req;
    logic        mis;
    logic [31:0] off;
    int          idx;
    logic [31:0] new_r;
    req = rd | wr;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    off = addr - BASE;
    idx = int'((off >> 2) & 32'(DEPTH - 1));
    new_r = cur_rdata;
    if (req) begin
      if (mis)     new_r = 32'd0;
      else if (wr) new_r = wd;
      else         new_r = mdl_mem[idx];
    end
    @(posedge clk); #1;
    mem_read_in   = rd;
    mem_write_in  = wr;
    address_in    = addr;
    store_data_in = wd;
    if (!req) begin
      exp_ready = 1'b1;
      exp_data  = cur_rdata;
      exp_fault = 1'b0;
    end else begin
      for (int k = 0; k <= W + 1; k++) begin
        if (k > 0) begin
          @(posedge clk); #1;
        end
        exp_ready = (k == W + 1);
        exp_data  = (k == W + 1) ? new_r : cur_rdata;
        exp_fault = (k == W + 1) && mis;
      end
      if (wr && !mis) mdl_mem[idx] = wd;
      cur_rdata = new_r;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    cur_rdata     = 32'd0;
    rst           = 1'b1;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    address_in    = 32'd0;
    store_data_in = 32'd0;
    exp_ready     = 1'b1;
    exp_data      = 32'd0;
    exp_fault     = 1'b0;
    chk_en        = 1'b1;

    // Reset with and without a pending request: ready follows !req.
    repeat (2) @(posedge clk);
    #1 mem_read_in = 1'b1; exp_ready = 1'b0;
    @(posedge clk); #1 mem_read_in = 1'b0; exp_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Store then load.
    run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("store_ready_pattern", 32'(rdy_log[4:0]), 32'b00001);
    run_op(1'b1, 1'b0, 32'd1028, 32'd0);
    @(negedge clk); #1;
    chk("load_1028", data_mem_out, 32'hDEADBEEF);

    // Wrap-around: index 64 aliases index 0.
    run_op(1'b0, 1'b1, 32'd1280, 32'h11);
    run_op(1'b1, 1'b0, 32'd1024, 32'd0);
    @(negedge clk); #1;
    chk("wrap_load_1024", data_mem_out, 32'h11);

    // Back-to-back loads then a non-memory instruction.
    run_op(1'b1, 1'b0, 32'd1028, 32'd0);
    run_op(1'b1, 1'b0, 32'd1024, 32'd0);
    run_op(1'b0, 1'b0, 32'd1099, 32'd5);
    @(negedge clk); #1;
    chk("b2b_ready_pattern", 32'(rdy_log[10:0]), 32'b00001000011);

    // Reset in the second WAIT cycle of a store.
    @(posedge clk); #1;
    mem_write_in = 1'b1; mem_read_in = 1'b0;
    address_in = 32'd1032; store_data_in = 32'h55;
    exp_ready = 1'b0; exp_data = cur_rdata; exp_fault = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write_in = 1'b0;
    exp_ready = 1'b1; exp_data = 32'd0;
    cur_rdata = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    run_op(1'b1, 1'b0, 32'd1032, 32'd0);
    @(negedge clk); #1;
    chk("reset_abort_load_1032", data_mem_out, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned store: suppressed, faults in DONE only.
    run_op(1'b0, 1'b1, 32'd1030, 32'h77);
    @(negedge clk); #1;
    chk("align_fault_done", 32'(align_fault), 32'd1);
    chk("align_rdata_zero", data_mem_out, 32'd0);
    run_op(1'b1, 1'b0, 32'd1028, 32'd0);
    @(negedge clk); #1;
    chk("align_load_1028", data_mem_out, 32'hDEADBEEF);
    chk("align_fault_cleared", 32'(align_fault), 32'd0);
`endif

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      a = 32'd768 + 32'($urandom_range(0, 191)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      case (kind)
        0, 1, 2: run_op(1'b1, 1'b0, a, $urandom);
        3, 4, 5: run_op(1'b0, 1'b1, a, $urandom);
        6:       run_op(1'b1, 1'b1, a, $urandom);
        default: run_op(1'b0, 1'b0, a, $urandom);
      endcase
    end
    run_op(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
